// File: rtl/track_frame_pkg.sv
// track_frame_pkg: shared constants for the track framer.
// Build option: define TRACK_FRAME_TS_EN to carry a 32-bit timestamp per track
// and emit it as a second header word.
package track_frame_pkg;

   localparam logic [15:0] HDR_MARK_DEF  = 16'hA55A;
   localparam logic [15:0] TAIL_MARK_DEF = 16'h5AA5;

   // read-side FSM encoding
   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_HDR  = 3'd1;
   localparam logic [2:0] ST_TS   = 3'd2;
   localparam logic [2:0] ST_DATA = 3'd3;
   localparam logic [2:0] ST_TAIL = 3'd4;

   // FIFO entry layout: {[ts], sof, trk, data}
   localparam int unsigned DATA_LSB = 0;
   localparam int unsigned DATA_W   = 32;
   localparam int unsigned TRK_LSB  = 32;
   localparam int unsigned TRK_W    = 16;
   localparam int unsigned SOF_BIT  = 48;
`ifdef TRACK_FRAME_TS_EN
   localparam int unsigned TS_LSB   = 49;
   localparam int unsigned TS_W     = 32;
   localparam int unsigned ENTRY_W  = 81;
`else
   localparam int unsigned ENTRY_W  = 49;
`endif

endpackage

// File: rtl/track_frame_fifo.sv
// track_frame_fifo: single-clock first-word-fall-through FIFO.
// rd_data always shows the head entry while empty is low.
module track_frame_fifo #(
   parameter int unsigned WIDTH = 49,
   parameter int unsigned DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             wr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             wr_ok;
   logic             rd_ok;

   assign full    = count[AW];
   assign empty   = (count == '0);
   assign wr_ok   = wr & ~full;
   assign rd_ok   = rd & ~empty;
   assign rd_data = mem[rd_ptr];

   // pointer and occupancy tracking
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
         if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
         case ({wr_ok, rd_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // storage array, no reset needed
   always_ff @(posedge clk) begin
      if (wr_ok) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/track_frame_pack.sv
// track_frame_pack: frames per-track FIR samples into a 32-bit valid/ready
// stream (header, [timestamp], samples, trailer).
// Build option: TRACK_FRAME_TS_EN adds the timestamp word and its counter.
module track_frame_pack
   import track_frame_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 16,
   parameter logic [15:0] HDR_MARK   = HDR_MARK_DEF,
   parameter logic [15:0] TAIL_MARK  = TAIL_MARK_DEF
) (
   input  logic        cfg_clk,
   input  logic        cfg_rst_n,
   input  logic        soft_rst,
   input  logic        track_pos,
   input  logic [15:0] track_num,
   input  logic        din_vld,
   input  logic [31:0] din,
   input  logic        seg_close,
   output logic [31:0] m_data,
   output logic        m_vld,
   output logic        m_last,
   input  logic        m_rdy,
   output logic        ovf_sticky,
   output logic [15:0] drop_cnt
);

   logic               trk_open;
   logic               pend_sof;
   logic [15:0]        pend_trk;
   logic               close_pend;
   logic               eff_sof;
   logic [15:0]        eff_trk;
   logic               wr_take;
   logic               fifo_wr;
   logic               fifo_rd;
   logic               fifo_full;
   logic               fifo_empty;
   logic [ENTRY_W-1:0] wr_entry;
   logic [ENTRY_W-1:0] head;
   logic               head_sof;
   logic [15:0]        head_trk;
   logic [31:0]        head_data;
   logic [2:0]         state;
   logic [2:0]         state_nxt;
   logic [15:0]        wcnt;
   logic               sof_own;
   logic               hs;
   logic               idle_clr;
   logic               tail_done;

   // a same-cycle track_pos claims the sample for the new track
   assign eff_sof   = track_pos | pend_sof;
   assign eff_trk   = track_pos ? track_num : pend_trk;
   assign wr_take   = din_vld & (track_pos | trk_open);
   assign fifo_wr   = wr_take & ~fifo_full;

   assign head_sof  = head[SOF_BIT];
   assign head_trk  = head[TRK_LSB +: TRK_W];
   assign head_data = head[DATA_LSB +: DATA_W];
   assign hs        = m_vld & m_rdy;

`ifdef TRACK_FRAME_TS_EN
   logic [31:0] ts_cnt;
   logic [31:0] pend_ts;
   logic [31:0] head_ts;

   assign wr_entry = {(track_pos ? ts_cnt : pend_ts), eff_sof, eff_trk, din};
   assign head_ts  = head[TS_LSB +: TS_W];

   // free-running timestamp counter
   always_ff @(posedge cfg_clk or negedge cfg_rst_n) begin
      if (!cfg_rst_n)    ts_cnt <= '0;
      else if (soft_rst) ts_cnt <= '0;
      else               ts_cnt <= ts_cnt + 32'd1;
   end
`else
   assign wr_entry = {eff_sof, eff_trk, din};
`endif

   track_frame_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (cfg_clk),
      .rst_n   (cfg_rst_n),
      .clr     (soft_rst),
      .wr      (fifo_wr),
      .wr_data (wr_entry),
      .rd      (fifo_rd),
      .rd_data (head),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // write-side tagging, overflow accounting
   always_ff @(posedge cfg_clk or negedge cfg_rst_n) begin
      if (!cfg_rst_n) begin
         trk_open   <= 1'b0;
         pend_sof   <= 1'b0;
         pend_trk   <= '0;
         ovf_sticky <= 1'b0;
         drop_cnt   <= '0;
`ifdef TRACK_FRAME_TS_EN
         pend_ts    <= '0;
`endif
      end else if (soft_rst) begin
         trk_open   <= 1'b0;
         pend_sof   <= 1'b0;
         pend_trk   <= '0;
         ovf_sticky <= 1'b0;
         drop_cnt   <= '0;
`ifdef TRACK_FRAME_TS_EN
         pend_ts    <= '0;
`endif
      end else begin
         if (seg_close) trk_open <= 1'b0;
         if (track_pos) begin
            trk_open <= 1'b1;
            pend_sof <= 1'b1;
            pend_trk <= track_num;
`ifdef TRACK_FRAME_TS_EN
            pend_ts  <= ts_cnt;
`endif
         end
         if (wr_take) begin
            if (!fifo_full) begin
               pend_sof <= 1'b0;
            end else begin
               ovf_sticky <= 1'b1;
               if (drop_cnt != '1) drop_cnt <= drop_cnt + 16'd1;
            end
         end
      end
   end

   // read FSM: next state, output word and FIFO pop
   always_comb begin
      state_nxt = state;
      m_vld     = 1'b0;
      m_last    = 1'b0;
      m_data    = '0;
      fifo_rd   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!fifo_empty) begin
               if (head_sof) state_nxt = ST_HDR;
               else          fifo_rd   = 1'b1;
            end
         end
         ST_HDR: begin
            m_vld  = 1'b1;
            m_data = {HDR_MARK, head_trk};
`ifdef TRACK_FRAME_TS_EN
            if (m_rdy) state_nxt = ST_TS;
`else
            if (m_rdy) state_nxt = ST_DATA;
`endif
         end
`ifdef TRACK_FRAME_TS_EN
         ST_TS: begin
            m_vld  = 1'b1;
            m_data = head_ts;
            if (m_rdy) state_nxt = ST_DATA;
         end
`endif
         ST_DATA: begin
            // the sof entry that opened this frame carries its first sample
            if (!fifo_empty) begin
               if (head_sof && !sof_own) begin
                  state_nxt = ST_TAIL;
               end else begin
                  m_vld   = 1'b1;
                  m_data  = head_data;
                  fifo_rd = m_rdy;
               end
            end else if (close_pend) begin
               state_nxt = ST_TAIL;
            end
         end
         ST_TAIL: begin
            m_vld  = 1'b1;
            m_last = 1'b1;
            m_data = {TAIL_MARK, wcnt};
            if (m_rdy) state_nxt = (!fifo_empty && head_sof) ? ST_HDR : ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // read FSM state, word count and first-entry ownership
   always_ff @(posedge cfg_clk or negedge cfg_rst_n) begin
      if (!cfg_rst_n) begin
         state   <= ST_IDLE;
         wcnt    <= '0;
         sof_own <= 1'b0;
      end else if (soft_rst) begin
         state   <= ST_IDLE;
         wcnt    <= '0;
         sof_own <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == ST_HDR && hs) wcnt <= '0;
         if (state == ST_DATA && fifo_rd && wcnt != '1) wcnt <= wcnt + 16'd1;
         if (state != ST_DATA && state_nxt == ST_DATA) sof_own <= 1'b1;
         else if (state == ST_DATA && fifo_rd)          sof_own <= 1'b0;
      end
   end

   // close_pend tracks whether the newest track has been closed: a new track
   // supersedes an older close, and a trailer forced by the next sof keeps it
   assign idle_clr  = (state == ST_IDLE) && fifo_empty && !fifo_wr;
   assign tail_done = (state == ST_TAIL) && hs && (state_nxt == ST_IDLE);

   // close request bookkeeping
   always_ff @(posedge cfg_clk or negedge cfg_rst_n) begin
      if (!cfg_rst_n)     close_pend <= 1'b0;
      else if (soft_rst)  close_pend <= 1'b0;
      else if (idle_clr)  close_pend <= 1'b0;
      else if (track_pos) close_pend <= 1'b0;
      else if (seg_close) close_pend <= 1'b1;
      else if (tail_done) close_pend <= 1'b0;
   end

endmodule
